// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - round-robin wormhole output-port arbiter with a one-flit output register
module noc_output_arbiter #(
  parameter int  NUM_REQ       = 5,
  parameter int  DATA_WIDTH    = 32,
  parameter int  MAX_PKT_FLITS = 16,
  localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          err_overlength
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  // Flit count at which a packet without a tail is forcibly terminated.
  localparam logic [7:0]       CNT_LIMIT = 8'(MAX_PKT_FLITS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        rr_after_grant;
  logic [IDX_W-1:0]        winner;
  logic                    any_req;
  logic [7:0]              flit_cnt;
  logic                    sel_valid;
  logic                    sel_last;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    out_free;
  logic                    accept;
  logic                    overlen;
  logic                    pkt_end;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    logic [IDX_W-1:0] cand;
    winner  = rr_ptr;
    any_req = 1'b0;
    cand    = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_req && req_valid[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
    end
  end

  // Mux the locked requester's flit, valid and tail marker.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IDX_W'(k)) begin
        sel_valid = req_valid[k];
        sel_last  = req_last[k];
        sel_data  = req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // The output register can take a flit when empty or draining this cycle.
  assign out_free       = !out_valid || out_ready;
  assign accept         = (state == LOCKED) && sel_valid && out_free;
  assign overlen        = accept && !sel_last && (flit_cnt == CNT_LIMIT);
  assign pkt_end        = accept && (sel_last || overlen);
  assign rr_after_grant = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
  assign grant_valid    = (state == LOCKED);

  // Only the locked requester sees ready; nobody is accepted while arbitrating.
  always_comb begin
    req_ready = '0;
    if (state == LOCKED) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        req_ready[k] = (grant_idx == IDX_W'(k)) && out_free;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: lock onto a winner, release after the tail (real or forced).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOCKED;
      LOCKED:  if (pkt_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant index, round-robin pointer, packet flit counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_idx      <= '0;
      rr_ptr         <= '0;
      flit_cnt       <= '0;
      err_overlength <= 1'b0;
    end else begin
      if (state == IDLE && any_req) begin
        grant_idx <= winner;
        flit_cnt  <= '0;
      end else if (accept) begin
        flit_cnt <= flit_cnt + 8'd1;
      end
      if (pkt_end) begin
        rr_ptr <= rr_after_grant;
      end
      if (overlen) begin
        err_overlength <= 1'b1;
      end
    end
  end

  // Output register: load on accept, hold while stalled, clear after a plain drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last || overlen;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - directed scoreboard bench for noc_output_arbiter
module tb_noc_output_arbiter;

  localparam int NR   = 5;
  localparam int DW   = 32;
  localparam int MAXF = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic            out_ready;
  logic            grant_valid;
  logic [2:0]      grant_idx;
  logic            err_overlength;

  logic [DW:0]     src_q [NR][$];
  logic [DW:0]     exp_q [$];
  logic [NR-1:0]   hold;
  logic [NR-1:0]   acc;
  logic            xfer;
  int              n_checks = 0;
  int              n_pass   = 0;

  noc_output_arbiter #(
    .NUM_REQ(NR),
    .DATA_WIDTH(DW),
    .MAX_PKT_FLITS(MAXF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_last(out_last),
    .out_ready(out_ready),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .err_overlength(err_overlength)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic src(input int k, input logic last, input logic [DW-1:0] d);
    src_q[k].push_back({last, d});
  endtask

  task automatic expect_flit(input logic last, input logic [DW-1:0] d);
    exp_q.push_back({last, d});
  endtask

  // Present the head of every source queue, honouring the hold mask.
  task automatic drive();
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    logic [DW:0]      e;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < NR; k++) begin
      if (src_q[k].size() > 0) begin
        e = src_q[k][0];
        v[k] = !hold[k];
        l[k] = e[DW];
        d[k*DW +: DW] = e[DW-1:0];
      end
    end
    req_valid = v;
    req_last  = l;
    req_data  = d;
    #1;
  endtask

  // One clock: sample handshakes at negedge, score output, advance sources.
  task automatic cyc();
    logic [DW:0] e;
    @(negedge clk);
    acc  = rst ? '0 : (req_valid & req_ready);
    xfer = !rst && out_valid && out_ready;
    if (xfer) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_flit", 64'(exp_q.size() > 0), 64'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_flit", {31'd0, out_last, out_data}, {31'd0, e});
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NR; k++) begin
      if (acc[k]) void'(src_q[k].pop_front());
    end
    drive();
  endtask

  initial begin
    int  order [6];
    bit  found;
    order = '{0, 1, 2, 3, 4, 0};

    // Reset
    rst       = 1'b1;
    out_ready = 1'b1;
    hold      = '0;
    drive();
    cyc();
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_err", err_overlength, 0);
    chk("rst_req_ready", req_ready, 0);
    rst = 1'b0;

    // Requester 2 sends a 3-flit packet
    src(2, 1'b0, 32'hA1); src(2, 1'b0, 32'hA2); src(2, 1'b1, 32'hA3);
    expect_flit(1'b0, 32'hA1); expect_flit(1'b0, 32'hA2); expect_flit(1'b1, 32'hA3);
    drive();
    chk("s1_idle_ready", req_ready, 0);
    chk("s1_idle_gv", grant_valid, 0);
    cyc();
    chk("s1_gv", grant_valid, 1);
    chk("s1_gi", grant_idx, 2);
    chk("s1_ready", req_ready, 5'b00100);
    cyc();
    chk("s1_f1", {out_valid, out_last, out_data}, {2'b10, 32'hA1});
    cyc();
    chk("s1_f2", {out_valid, out_last, out_data}, {2'b10, 32'hA2});
    cyc();
    chk("s1_f3", {out_valid, out_last, out_data}, {2'b11, 32'hA3});
    chk("s1_idle_after_tail", grant_valid, 0);
    cyc();
    chk("s1_out_cleared", out_valid, 0);

    // rr_ptr is 3: requester 4 beats requester 1
    src(1, 1'b1, 32'hB1); src(4, 1'b1, 32'hC4);
    expect_flit(1'b1, 32'hC4); expect_flit(1'b1, 32'hB1);
    drive();
    cyc();
    chk("s1_rr_gi4", grant_idx, 4);
    cyc();
    cyc();
    chk("s1_rr_gi1", grant_idx, 1);
    cyc();
    cyc();
    chk("s1_sb_empty", exp_q.size(), 0);

    // All five requesters hold 1-flit packets from reset
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    src(0, 1'b1, 32'hD0); src(0, 1'b1, 32'hD5);
    for (int k = 1; k < NR; k++) src(k, 1'b1, 32'hD0 + 32'(k));
    for (int k = 0; k < 6; k++) expect_flit(1'b1, 32'hD0 + 32'(k));
    drive();
    for (int p = 0; p < 6; p++) begin
      cyc();
      chk("s2_gv", grant_valid, 1);
      chk("s2_gi", grant_idx, 64'(order[p]));
      cyc();
      chk("s2_released", grant_valid, 0);
    end
    cyc();
    cyc();
    chk("s2_sb_empty", exp_q.size(), 0);

    // Output stall for 4 cycles mid-packet (rr_ptr now 1)
    src(1, 1'b0, 32'hE1); src(1, 1'b0, 32'hE2); src(1, 1'b1, 32'hE3);
    expect_flit(1'b0, 32'hE1); expect_flit(1'b0, 32'hE2); expect_flit(1'b1, 32'hE3);
    drive();
    cyc();
    chk("s3_gi", grant_idx, 1);
    cyc();
    chk("s3_first", out_data, 32'hE1);
    out_ready = 1'b0;
    #1;
    chk("s3_ready_low", req_ready, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("s3_stall_data", {out_valid, out_data}, {1'b1, 32'hE1});
      chk("s3_stall_ready", req_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc();
    chk("s3_sb_empty", exp_q.size(), 0);
    chk("s3_src_empty", src_q[1].size(), 0);
    chk("s3_no_err", err_overlength, 0);

    // Overlength: requester 1 sends 6 flits without a tail (rr_ptr now 2)
    for (int i = 1; i <= 6; i++) src(1, 1'b0, 32'hF0 + 32'(i));
    for (int i = 1; i <= 3; i++) expect_flit(1'b0, 32'hF0 + 32'(i));
    expect_flit(1'b1, 32'hF4);
    drive();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      if (out_valid && out_data == 32'hF4) found = 1'b1;
    end
    chk("s4_f4_seen", found, 1);
    chk("s4_forced_last", out_last, 1);
    chk("s4_err", err_overlength, 1);
    chk("s4_rearbitrate", grant_valid, 0);
    src(2, 1'b1, 32'hC2);
    expect_flit(1'b1, 32'hC2);
    expect_flit(1'b0, 32'hF5);
    drive();
    cyc();
    chk("s4_rr2_gi", grant_idx, 2);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      cyc();
      if (out_valid && out_data == 32'hF6) found = 1'b1;
    end
    chk("s4_f6_seen", found, 1);
    out_ready = 1'b0;
    #1;
    chk("s4_err_sticky", err_overlength, 1);
    chk("s4_relock_gi", grant_idx, 1);
    cyc();
    chk("s4_lock_held", grant_valid, 1);
    chk("s4_sb_empty", exp_q.size(), 0);

    // Reset while LOCKED with a buffered flit
    rst = 1'b1;
    cyc();
    chk("s5_out_valid", out_valid, 0);
    chk("s5_out_data", out_data, 0);
    chk("s5_out_last", out_last, 0);
    chk("s5_gv", grant_valid, 0);
    chk("s5_gi", grant_idx, 0);
    chk("s5_err", err_overlength, 0);
    chk("s5_ready", req_ready, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    src(0, 1'b1, 32'h50); src(3, 1'b1, 32'h53);
    expect_flit(1'b1, 32'h50); expect_flit(1'b1, 32'h53);
    drive();
    cyc();
    chk("s5_first_gi0", grant_idx, 0);
    cyc();
    cyc();
    chk("s5_second_gi3", grant_idx, 3);
    cyc();
    cyc();
    chk("s5_sb_empty", exp_q.size(), 0);

    // Requester 3 drops valid mid-packet while requester 0 waits (rr_ptr now 4)
    src(3, 1'b0, 32'h61); src(3, 1'b0, 32'h62); src(3, 1'b1, 32'h63);
    expect_flit(1'b0, 32'h61); expect_flit(1'b0, 32'h62); expect_flit(1'b1, 32'h63);
    expect_flit(1'b1, 32'h70);
    drive();
    cyc();
    chk("s6_gi3", grant_idx, 3);
    cyc();
    hold[3] = 1'b1;
    src(0, 1'b1, 32'h70);
    drive();
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("s6_hold_gv", grant_valid, 1);
      chk("s6_hold_gi", grant_idx, 3);
    end
    hold[3] = 1'b0;
    drive();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cyc();
      if (!grant_valid) found = 1'b1;
    end
    chk("s6_released", found, 1);
    chk("s6_tail", {out_last, out_data}, {1'b1, 32'h63});
    cyc();
    chk("s6_next_gv", grant_valid, 1);
    chk("s6_next_gi0", grant_idx, 0);
    for (int i = 0; i < 4; i++) cyc();
    chk("s6_sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
